riscv_soft_scoreboard: RTL and testbench

- Parametrised register scoreboard and hazard unit for the next-generation riscv_soft pipeline. It replaces fixed single-WB-stage forwarding with tracking of pending register writes from NUM_WB independent long-latency writeback channels (e.g. ALU, d_cache, multiplier).
- Sits beside the EX stage: gates instruction issue on RAW and WAW hazards and on an in-flight limit.
- Supplies same-cycle writeback bypass selects to the EX operand muxes.

---
 rtl/riscv_soft_scoreboard.sv | 128 ++++++++++++
 tb/tb_riscv_soft_scoreboard.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_soft_scoreboard.sv
// Register scoreboard: tracks pending writes from NUM_WB writeback channels and gates issue on RAW/WAW/in-flight limits.
// issue_ready/fwd are combinational; pending updates next edge. RISCV_SOFT_SCOREBOARD_WB_BYPASS_EN enables same-cycle wb bypass.
module riscv_soft_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int NUM_WB       = 2,
  parameter int WB_SEL_W     = 1,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [REG_ADDR_W-1:0]        issue_rs1,
  input  logic                         issue_rs1_used,
  input  logic [REG_ADDR_W-1:0]        issue_rs2,
  input  logic                         issue_rs2_used,
  input  logic [REG_ADDR_W-1:0]        issue_rd,
  input  logic                         issue_wr_reg,
  input  logic [WB_SEL_W-1:0]          issue_wb_sel,
  input  logic [NUM_WB-1:0]            wb_valid,
  input  logic [NUM_WB*REG_ADDR_W-1:0] wb_rd,
  input  logic                         flush,
  output logic                         fwd_rs1_valid,
  output logic [WB_SEL_W-1:0]          fwd_rs1_sel,
  output logic                         fwd_rs2_valid,
  output logic [WB_SEL_W-1:0]          fwd_rs2_sel,
  output logic                         wb_err,
  output logic                         busy,
  output logic [CNT_W-1:0]             inflight_count
);

  localparam int NM_W = $clog2(NUM_WB + 1);

  logic [NUM_REGS-1:0] pending;
  logic [WB_SEL_W-1:0] tag [NUM_REGS];
  logic [CNT_W-1:0]    cnt_q;
  logic                wb_err_q;

  logic [NUM_WB-1:0]     match;
  logic [NUM_WB-1:0]     mismatch;
  logic [NUM_REGS-1:0]   clr_vec;
  logic [NUM_REGS-1:0]   clr_now;
  logic [NUM_REGS-1:0]   set_vec;
  logic [NM_W-1:0]       n_match;
  logic [NM_W-1:0]       n_bypass;
  logic [REG_ADDR_W-1:0] rd_k;
  logic                  rs1_haz, rs2_haz, waw_haz, full;
  logic                  alloc;
  logic [CNT_W:0]        eff_cnt;
  logic [CNT_W:0]        cnt_sum;

  // A channel only retires a register whose tag names that channel; anything else is an error.
  always_comb begin
    match    = '0;
    mismatch = '0;
    clr_vec  = '0;
    n_match  = '0;
    rd_k     = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      rd_k = wb_rd[k*REG_ADDR_W +: REG_ADDR_W];
      if (wb_valid[k] && rd_k != '0) begin
        if (pending[rd_k] && tag[rd_k] == WB_SEL_W'(k)) begin
          match[k]      = 1'b1;
          clr_vec[rd_k] = 1'b1;
          n_match       = n_match + NM_W'(1);
        end else begin
          mismatch[k] = 1'b1;
        end
      end
    end
  end

`ifdef RISCV_SOFT_SCOREBOARD_WB_BYPASS_EN
  assign clr_now  = clr_vec;
  assign n_bypass = n_match;
`else
  assign clr_now  = '0;
  assign n_bypass = '0;
`endif

  assign rs1_haz = issue_rs1_used && issue_rs1 != '0 && pending[issue_rs1] && !clr_now[issue_rs1];
  assign rs2_haz = issue_rs2_used && issue_rs2 != '0 && pending[issue_rs2] && !clr_now[issue_rs2];
  assign waw_haz = issue_wr_reg && issue_rd != '0 && pending[issue_rd] && !clr_now[issue_rd];

  assign eff_cnt = {1'b0, cnt_q} - (CNT_W+1)'(n_bypass);
  assign full    = issue_wr_reg && eff_cnt == (CNT_W+1)'(MAX_INFLIGHT);

  assign issue_ready = !flush && !rs1_haz && !rs2_haz && !waw_haz && !full;
  assign alloc       = issue_valid && issue_ready && issue_wr_reg && issue_rd != '0;

  assign fwd_rs1_valid = issue_rs1_used && issue_rs1 != '0 && pending[issue_rs1] && clr_now[issue_rs1];
  assign fwd_rs2_valid = issue_rs2_used && issue_rs2 != '0 && pending[issue_rs2] && clr_now[issue_rs2];
  assign fwd_rs1_sel   = fwd_rs1_valid ? tag[issue_rs1] : '0;
  assign fwd_rs2_sel   = fwd_rs2_valid ? tag[issue_rs2] : '0;

  always_comb begin
    set_vec = '0;
    if (alloc) set_vec[issue_rd] = 1'b1;
  end

  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(alloc) - (CNT_W+1)'(n_match);

  // Set is OR-ed after the clear so a re-issued rd stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      cnt_q    <= '0;
      wb_err_q <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) tag[r] <= '0;
    end else if (flush) begin
      pending  <= '0;
      cnt_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      pending  <= (pending & ~clr_vec) | set_vec;
      cnt_q    <= cnt_sum[CNT_W-1:0];
      wb_err_q <= |mismatch;
      if (alloc) tag[issue_rd] <= issue_wb_sel;
    end
  end

  assign wb_err         = wb_err_q;
  assign busy           = cnt_q != '0;
  assign inflight_count = cnt_q;

endmodule

// File: tb/tb_riscv_soft_scoreboard.sv
// Directed bench for riscv_soft_scoreboard; expectations follow RISCV_SOFT_SCOREBOARD_WB_BYPASS_EN when defined.
module tb_riscv_soft_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_ready;
  logic [4:0] issue_rs1, issue_rs2, issue_rd;
  logic       issue_rs1_used, issue_rs2_used, issue_wr_reg;
  logic [0:0] issue_wb_sel;
  logic [1:0] wb_valid;
  logic [9:0] wb_rd;
  logic       flush;
  logic       fwd_rs1_valid, fwd_rs2_valid;
  logic [0:0] fwd_rs1_sel, fwd_rs2_sel;
  logic       wb_err, busy;
  logic [2:0] inflight_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  riscv_soft_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_wr_reg(issue_wr_reg), .issue_wb_sel(issue_wb_sel),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .fwd_rs1_valid(fwd_rs1_valid), .fwd_rs1_sel(fwd_rs1_sel),
    .fwd_rs2_valid(fwd_rs2_valid), .fwd_rs2_sel(fwd_rs2_sel),
    .wb_err(wb_err), .busy(busy), .inflight_count(inflight_count)
  );

  task automatic chk(input string t, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs1_used = 0; issue_rs2 = 0; issue_rs2_used = 0;
    issue_rd = 0; issue_wr_reg = 0; issue_wb_sel = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic writer(input logic [4:0] rd, input logic sel);
    issue_valid = 1; issue_wr_reg = 1; issue_rd = rd; issue_wb_sel = sel;
  endtask

  task automatic wb(input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1);
    wb_valid = v; wb_rd = {r1, r0};
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_count", inflight_count, 0);
    chk("rst_ready", issue_ready, 1);
    chk("rst_wb_err", wb_err, 0);
    chk("rst_fwd1", fwd_rs1_valid, 0);

    // RAW on rd=5 returned by channel 1
    writer(5, 1); #1;
    chk("raw_issue_ready", issue_ready, 1);
    tick();
    issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1; #1;
    chk("raw_stall", issue_ready, 0);
    chk("raw_count", inflight_count, 1);
    tick();
    issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1; wb(2'b10, 0, 5); #1;
`ifdef RISCV_SOFT_SCOREBOARD_WB_BYPASS_EN
    chk("raw_bypass_ready", issue_ready, 1);
    chk("raw_fwd_valid", fwd_rs1_valid, 1);
    chk("raw_fwd_sel", fwd_rs1_sel, 1);
    tick();
`else
    chk("raw_wb_ready", issue_ready, 0);
    chk("raw_fwd_valid", fwd_rs1_valid, 0);
    chk("raw_fwd_sel", fwd_rs1_sel, 0);
    tick();
    issue_valid = 1; issue_rs1 = 5; issue_rs1_used = 1; #1;
    chk("raw_late_ready", issue_ready, 1);
    tick();
`endif
    chk("raw_count_done", inflight_count, 0);

    // In-flight limit
    for (int i = 1; i <= 4; i++) begin
      writer(5'(i), 0); #1;
      chk("fill_ready", issue_ready, 1);
      tick();
    end
    chk("full_count", inflight_count, 4);
    chk("full_busy", busy, 1);
    writer(6, 0); #1;
    chk("full_stall", issue_ready, 0);
    tick();
    issue_valid = 1; issue_rs1 = 10; issue_rs1_used = 1; #1;
    chk("full_nonwriter", issue_ready, 1);
    tick();
    wb(2'b01, 2, 0);
    tick();
    chk("retire_count", inflight_count, 3);
    chk("retire_err", wb_err, 0);
    wb(2'b01, 1, 0); tick();
    wb(2'b01, 3, 0); tick();
    wb(2'b01, 4, 0); tick();
    chk("drain_count", inflight_count, 0);

    // WAW on rd=7, retag from channel 0 to channel 1
    writer(7, 0); tick();
    writer(7, 1); wb(2'b01, 7, 0); #1;
`ifdef RISCV_SOFT_SCOREBOARD_WB_BYPASS_EN
    chk("waw_ready", issue_ready, 1);
    tick();
    chk("waw_count", inflight_count, 1);
`else
    chk("waw_ready", issue_ready, 0);
    tick();
    chk("waw_count_clr", inflight_count, 0);
    writer(7, 1); #1;
    chk("waw_reissue", issue_ready, 1);
    tick();
    chk("waw_count", inflight_count, 1);
`endif
    wb(2'b10, 0, 7); tick();
    chk("waw_tag1_err", wb_err, 0);
    chk("waw_tag1_count", inflight_count, 0);

    // Wrong channel for rd=9
    writer(9, 0); tick();
    wb(2'b10, 0, 9); tick();
    chk("mm_err", wb_err, 1);
    chk("mm_count", inflight_count, 1);
    issue_valid = 1; issue_rs1 = 9; issue_rs1_used = 1; #1;
    chk("mm_still_pending", issue_ready, 0);
    tick();
    chk("mm_err_pulse", wb_err, 0);
    wb(2'b01, 9, 0); tick();
    chk("mm_retire", inflight_count, 0);

    // x0 is never tracked
    writer(0, 0); issue_rs1 = 0; issue_rs1_used = 1; #1;
    chk("x0_ready", issue_ready, 1);
    tick();
    chk("x0_count", inflight_count, 0);
    wb(2'b01, 0, 0); tick();
    chk("x0_wb_err", wb_err, 0);

    // Flush
    writer(11, 0); tick();
    writer(12, 0); tick();
    writer(13, 0); tick();
    chk("pre_flush_count", inflight_count, 3);
    writer(14, 0); flush = 1; #1;
    chk("flush_ready", issue_ready, 0);
    tick();
    chk("flush_busy", busy, 0);
    chk("flush_count", inflight_count, 0);
    wb(2'b01, 11, 0); tick();
    chk("late_wb_err", wb_err, 1);

    // rs2 hazard, then reset mid-operation
    writer(20, 0); tick();
    issue_valid = 1; issue_rs2 = 20; issue_rs2_used = 1; #1;
    chk("rs2_stall", issue_ready, 0);
    chk("rs2_fwd", fwd_rs2_valid, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0; idle(); #1;
    chk("mid_rst_count", inflight_count, 0);
    chk("mid_rst_busy", busy, 0);
    issue_valid = 1; issue_rs2 = 20; issue_rs2_used = 1; #1;
    chk("mid_rst_ready", issue_ready, 1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
